// File: rtl/seq_pattern_tx_if.sv
// seq_pattern_tx_if: request/serial-output bundle for seq_pattern_tx.
//   master : drives start, pattern, len, repeat_cnt; observes serial outputs
//   slave  : the transmitter (receives requests, drives Data_out, Data_valid,
//            busy, done)
interface seq_pattern_tx_if #(
  parameter int PAT_W = 8,
  parameter int LEN_W = 4,
  parameter int CNT_W = 4
) ();
  logic             start;
  logic [PAT_W-1:0] pattern;
  logic [LEN_W-1:0] len;
  logic [CNT_W-1:0] repeat_cnt;
  logic             Data_out;
  logic             Data_valid;
  logic             busy;
  logic             done;

  modport master (
    output start, pattern, len, repeat_cnt,
    input  Data_out, Data_valid, busy, done
  );

  modport slave (
    input  start, pattern, len, repeat_cnt,
    output Data_out, Data_valid, busy, done
  );
endinterface

// File: rtl/seq_pattern_tx.sv
// seq_pattern_tx: serial bit-stream transmitter, MSB-first, one bit per clock.
//   Latches pattern/len/repeat_cnt on start (when idle), sends repeat_cnt+1
//   frames of len bits each, separated by GAP idle cycles, then pulses done.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous reset, active-high
//   bus  : seq_pattern_tx_if.slave (start, pattern, len, repeat_cnt in;
//          Data_out, Data_valid, busy, done out; all outputs registered)
// Optional feature: define SEQ_TX_PARITY_EN to append an even-parity bit
//   (XOR of the frame's len bits) after every frame.
module seq_pattern_tx #(
  parameter int PAT_W = 8,
  parameter int LEN_W = 4,
  parameter int CNT_W = 4,
  parameter int GAP   = 1
) (
  input  logic                clk,
  input  logic                rst,
  seq_pattern_tx_if.slave     bus
);

  localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_GAP
`ifdef SEQ_TX_PARITY_EN
    , ST_PAR
`endif
  } state_t;

  state_t             state_q, state_d;
  logic [PAT_W-1:0]   pat_q, pat_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [CNT_W-1:0]   rep_q, rep_d;
  logic [CNT_W-1:0]   frame_q, frame_d;
  logic [LEN_W-1:0]   bit_idx_q, bit_idx_d;
  logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic               dout_q, dout_d;
  logic               valid_q, valid_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [LEN_W-1:0]   eff_len;
  logic               eof;
  logic               restart;

  function automatic logic bit_at(input logic [PAT_W-1:0] p,
                                  input logic [LEN_W-1:0] i);
    logic [PAT_W-1:0] s;
    s = p >> i;
    return s[0];
  endfunction

`ifdef SEQ_TX_PARITY_EN
  function automatic logic parity_of(input logic [PAT_W-1:0] p,
                                     input logic [LEN_W-1:0] l);
    logic acc;
    acc = 1'b0;
    for (int unsigned k = 0; k < PAT_W; k++) begin
      if (k < 32'(l)) acc = acc ^ p[k];
    end
    return acc;
  endfunction
`endif

  // Out-of-range lengths (0 or wider than the pattern) mean "full width".
  always_comb begin
    eff_len = bus.len;
    if (bus.len == '0 || 32'(bus.len) > PAT_W) eff_len = LEN_W'(PAT_W);
  end

  always_comb begin
    state_d   = state_q;
    pat_d     = pat_q;
    len_d     = len_q;
    rep_d     = rep_q;
    frame_d   = frame_q;
    bit_idx_d = bit_idx_q;
    gap_cnt_d = gap_cnt_q;
    dout_d    = dout_q;
    valid_d   = valid_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    eof       = 1'b0;
    restart   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        busy_d  = 1'b0;
        valid_d = 1'b0;
        dout_d  = 1'b0;
        if (bus.start) begin
          pat_d     = bus.pattern;
          len_d     = eff_len;
          rep_d     = bus.repeat_cnt;
          frame_d   = '0;
          bit_idx_d = eff_len - 1'b1;
          dout_d    = bit_at(bus.pattern, eff_len - 1'b1);
          valid_d   = 1'b1;
          busy_d    = 1'b1;
          state_d   = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        // bit_idx_q is the index of the bit currently on Data_out.
        if (bit_idx_q != '0) begin
          bit_idx_d = bit_idx_q - 1'b1;
          dout_d    = bit_at(pat_q, bit_idx_q - 1'b1);
        end else begin
`ifdef SEQ_TX_PARITY_EN
          state_d = ST_PAR;
          dout_d  = parity_of(pat_q, len_q);
          valid_d = 1'b1;
`else
          eof = 1'b1;
`endif
        end
      end

`ifdef SEQ_TX_PARITY_EN
      ST_PAR: begin
        eof = 1'b1;
      end
`endif

      ST_GAP: begin
        if (gap_cnt_q == '0) restart = 1'b1;
        else                 gap_cnt_d = gap_cnt_q - 1'b1;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // End-of-frame handling is shared by SHIFT (no parity) and PAR.
    if (eof) begin
      if (frame_q < rep_q) begin
        frame_d = frame_q + 1'b1;
        if (GAP > 0) begin
          state_d   = ST_GAP;
          valid_d   = 1'b0;
          dout_d    = 1'b0;
          gap_cnt_d = GAP_W'(GAP - 1);
        end else begin
          restart = 1'b1;
        end
      end else begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        valid_d = 1'b0;
        dout_d  = 1'b0;
        done_d  = 1'b1;
      end
    end

    if (restart) begin
      state_d   = ST_SHIFT;
      bit_idx_d = len_q - 1'b1;
      dout_d    = bit_at(pat_q, len_q - 1'b1);
      valid_d   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      pat_q     <= '0;
      len_q     <= '0;
      rep_q     <= '0;
      frame_q   <= '0;
      bit_idx_q <= '0;
      gap_cnt_q <= '0;
      dout_q    <= 1'b0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pat_q     <= pat_d;
      len_q     <= len_d;
      rep_q     <= rep_d;
      frame_q   <= frame_d;
      bit_idx_q <= bit_idx_d;
      gap_cnt_q <= gap_cnt_d;
      dout_q    <= dout_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.Data_out   = dout_q;
  assign bus.Data_valid = valid_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;

endmodule

// File: tb/tb_seq_pattern_tx.sv
module tb_seq_pattern_tx;
  localparam int PAT_W = 8;
  localparam int LEN_W = 4;
  localparam int CNT_W = 4;
  localparam int GAP_P = 1;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  seq_pattern_tx_if #(.PAT_W(PAT_W), .LEN_W(LEN_W), .CNT_W(CNT_W)) bus ();

  seq_pattern_tx #(.PAT_W(PAT_W), .LEN_W(LEN_W), .CNT_W(CNT_W), .GAP(GAP_P)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: each accepted request expands into a queue of per-cycle
  // expected outputs {valid, out, busy, done}.
  logic [3:0] cur;
  logic [3:0] q[$];

  task automatic build(input logic [PAT_W-1:0] p, input logic [LEN_W-1:0] l,
                       input logic [CNT_W-1:0] r);
    int  L;
    logic par;
    L = (l == 0 || int'(l) > PAT_W) ? PAT_W : int'(l);
    for (int f = 0; f <= int'(r); f++) begin
      par = 1'b0;
      for (int b = L - 1; b >= 0; b--) begin
        q.push_back({1'b1, p[b], 1'b1, 1'b0});
        par = par ^ p[b];
      end
`ifdef SEQ_TX_PARITY_EN
      q.push_back({1'b1, par, 1'b1, 1'b0});
`endif
      if (f < int'(r))
        for (int g = 0; g < GAP_P; g++) q.push_back(4'b0010);
    end
    q.push_back(4'b0001);
  endtask

  initial cur = 4'b0000;

  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      cur <= 4'b0000;
    end else begin
      if (!cur[1] && bus.start) build(bus.pattern, bus.len, bus.repeat_cnt);
      if (q.size() > 0) cur <= q.pop_front();
      else              cur <= 4'b0000;
    end
  end

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    total++;
    if ({bus.Data_valid, bus.Data_out, bus.busy, bus.done} !== cur) begin
      bad++;
      $display("FAIL cycle_cmp t=%0t got v/o/b/d=%b%b%b%b want=%b", $time,
               bus.Data_valid, bus.Data_out, bus.busy, bus.done, cur);
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (bus.busy !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      total++;
      bad++;
      $display("FAIL wait_idle got=busy want=idle");
    end
  endtask

  // Hand-computed sequence: cycle i (1..n) expects valid=ev[n-i], out=ed[n-i],
  // then a done pulse in cycle n+1.
  task automatic directed(input string name, input logic [PAT_W-1:0] p,
                          input logic [LEN_W-1:0] l, input logic [CNT_W-1:0] r,
                          input int n, input logic [31:0] ev, input logic [31:0] ed);
    wait_idle();
    bus.start = 1'b1; bus.pattern = p; bus.len = l; bus.repeat_cnt = r;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 1; i <= n; i++) begin
      check({name, "_valid"}, {31'b0, bus.Data_valid}, {31'b0, ev[n-i]});
      check({name, "_data"},  {31'b0, bus.Data_out},   {31'b0, ed[n-i]});
      check({name, "_nodone"}, {31'b0, bus.done}, 32'd0);
      @(negedge clk);
    end
    check({name, "_done"}, {29'b0, bus.done, bus.busy, bus.Data_valid}, 32'b100);
  endtask

  initial begin
    int n;
    total = 0; bad = 0;
    rst = 1'b1;
    bus.start = 1'b0; bus.pattern = '0; bus.len = '0; bus.repeat_cnt = '0;
    repeat (3) @(negedge clk);
    check("reset_outs", {28'b0, bus.Data_valid, bus.Data_out, bus.busy, bus.done}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

`ifdef SEQ_TX_PARITY_EN
    directed("par_110", 8'h06, 4'd3, 4'd0, 4, 32'b1111, 32'b1100);
    directed("par_111", 8'h07, 4'd3, 4'd0, 4, 32'b1111, 32'b1111);
    directed("par_rep", 8'h06, 4'd3, 4'd1, 9, 32'b111101111, 32'b110001100);
    directed("par_len0", 8'h96, 4'd0, 4'd0, 9, 32'h1FF, 32'b100101100);
`else
    directed("t1_101", 8'h05, 4'd3, 4'd0, 3, 32'b111, 32'b101);
    directed("t2_rep", 8'h06, 4'd3, 4'd1, 7, 32'b1110111, 32'b1100110);
    directed("t5_len0", 8'h96, 4'd0, 4'd0, 8, 32'hFF, 32'h96);
    directed("len_big", 8'h3C, 4'd12, 4'd0, 8, 32'hFF, 32'h3C);
`endif

    // Restart mid-frame is ignored; start in the done cycle is accepted.
    wait_idle();
    bus.start = 1'b1; bus.pattern = 8'hF0; bus.len = 4'd8; bus.repeat_cnt = 4'd0;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    bus.start = 1'b1; bus.pattern = 8'h00;
    @(negedge clk);
    bus.start = 1'b0;
    check("ignore_restart", {31'b0, bus.Data_out}, 32'd1);
    n = 0;
    while (bus.done !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", {31'b0, bus.done}, 32'd1);
    bus.start = 1'b1; bus.pattern = 8'h03; bus.len = 4'd2;
    @(negedge clk);
    bus.start = 1'b0;
    check("chain_start", {28'b0, bus.Data_valid, bus.Data_out, bus.busy, bus.done}, 32'b1110);

    // Reset after the 2nd bit of 8'hA5 aborts without a done pulse.
    wait_idle();
    bus.start = 1'b1; bus.pattern = 8'hA5; bus.len = 4'd8; bus.repeat_cnt = 4'd0;
    @(negedge clk);
    bus.start = 1'b0;
    check("rst_bit1", {31'b0, bus.Data_out}, 32'd1);
    @(negedge clk);
    check("rst_bit2", {31'b0, bus.Data_out}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_abort", {28'b0, bus.Data_valid, bus.Data_out, bus.busy, bus.done}, 32'd0);
    repeat (3) begin
      @(negedge clk);
      check("rst_nodone", {31'b0, bus.done}, 32'd0);
    end
`ifdef SEQ_TX_PARITY_EN
    directed("after_rst", 8'hA5, 4'd8, 4'd0, 9, 32'h1FF, 32'b101001010);
`else
    directed("after_rst", 8'hA5, 4'd8, 4'd0, 8, 32'hFF, 32'hA5);
`endif

    // Randomized traffic, checked cycle by cycle against the model.
    for (int c = 0; c < 3000; c++) begin
      bus.start      = ($urandom_range(0, 3) == 0);
      bus.pattern    = PAT_W'($urandom);
      bus.len        = LEN_W'($urandom_range(0, 15));
      bus.repeat_cnt = CNT_W'($urandom_range(0, 3));
      rst            = ($urandom_range(0, 299) == 0);
      @(negedge clk);
    end
    rst = 1'b0;
    bus.start = 1'b0;
    wait_idle();
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
